// File: rtl/button_event_gen.sv
// Button front end: synchronises, debounces and classifies three raw buttons
// into single-cycle events, at most one event high per cycle.
module button_event_gen #(
   parameter int unsigned DB_CYCLES   = 16,
   parameter int unsigned LONG_CYCLES = 1000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_inc_raw,
   input  logic btn_set_raw,
   input  logic btn_sw_raw,
   output logic inc_short,
   output logic inc_long,
   output logic set,
   output logic sw
);

   localparam int unsigned NB = 3;   // button index: 0 inc, 1 set, 2 sw
   localparam int unsigned NE = 4;   // event index: 0 set, 1 sw, 2 long, 3 short
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      LONG_DONE = 2'd2
   } inc_state_e;

   logic [NB-1:0]    raw_c;
   logic [NB-1:0]    sync1_q, sync2_q;
   logic [NB-1:0]    lvl_q, lvl_d, prev_q;
   logic [NB-1:0]    rise_c;
   logic [CNT_W-1:0] db_cnt_q [NB];
   logic [CNT_W-1:0] db_cnt_d [NB];

   inc_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             new_short_c, new_long_c;

   logic [NE-1:0]    pend_q, pend_d, new_c, grant_c, out_q;

   assign raw_c  = {btn_sw_raw, btn_set_raw, btn_inc_raw};
   assign rise_c = lvl_q & ~prev_q;

   // Debounce: level flips after DB_CYCLES consecutive differing samples
   always_comb begin
      for (int b = 0; b < NB; b++) begin
         lvl_d[b]    = lvl_q[b];
         db_cnt_d[b] = '0;
         if (sync2_q[b] != lvl_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               lvl_d[b] = ~lvl_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   // inc press classifier next-state logic
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      new_short_c = 1'b0;
      new_long_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_c[0]) begin
               hold_d  = '0;
               state_d = HELD;
            end
         end
         HELD: begin
            if (!lvl_q[0]) begin
               new_short_c = 1'b1;
               state_d     = IDLE;
            end else begin
               if (hold_q != CNT_MAX) begin
                  hold_d = hold_q + CNT_W'(1);
               end
               if (hold_d == LONG_LAST) begin
                  new_long_c = 1'b1;
                  state_d    = LONG_DONE;
               end
            end
         end
         LONG_DONE: begin
            if (!lvl_q[0]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Fixed-priority arbiter: set > sw > inc_long > inc_short
   always_comb begin
      new_c   = {new_short_c, new_long_c, rise_c[2], rise_c[1]};
      grant_c = '0;
      if (pend_q[0]) begin
         grant_c[0] = 1'b1;
      end else if (pend_q[1]) begin
         grant_c[1] = 1'b1;
      end else if (pend_q[2]) begin
         grant_c[2] = 1'b1;
      end else if (pend_q[3]) begin
         grant_c[3] = 1'b1;
      end
      pend_d = (pend_q & ~grant_c) | new_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         prev_q  <= '0;
         for (int b = 0; b < NB; b++) begin
            db_cnt_q[b] <= '0;
         end
         state_q <= IDLE;
         hold_q  <= '0;
         pend_q  <= '0;
         out_q   <= '0;
      end else begin
         sync1_q <= raw_c;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         prev_q  <= lvl_q;
         for (int b = 0; b < NB; b++) begin
            db_cnt_q[b] <= db_cnt_d[b];
         end
         state_q <= state_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         out_q   <= grant_c;
      end
   end

   assign set       = out_q[0];
   assign sw        = out_q[1];
   assign inc_long  = out_q[2];
   assign inc_short = out_q[3];

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed latency scenarios plus
// randomized button activity compared every cycle against a behavioural model.
module tb_button_event_gen;

   localparam int unsigned DB   = 16;
   localparam int unsigned LONG = 1000;
   localparam int unsigned CW   = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic b_inc = 1'b0;
   logic b_set = 1'b0;
   logic b_sw  = 1'b0;
   logic inc_short, inc_long, set, sw;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit model_valid = 1'b0;

   // model state; events: 0 set, 1 sw, 2 long, 3 short; buttons: 0 inc, 1 set, 2 sw
   bit       lvl  [3];
   bit       up_p [3];
   bit       dn_p [3];
   bit       pend [4];
   bit       held;
   int       press_edge;
   bit [3:0] exp_out;
   bit       hist [3][$];

   int n_set, n_sw, n_long, n_short;
   int first_set, first_sw, first_long, first_short;

   always #5 clk = ~clk;

   button_event_gen #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_inc_raw(b_inc),
      .btn_set_raw(b_set),
      .btn_sw_raw (b_sw),
      .inc_short  (inc_short),
      .inc_long   (inc_long),
      .set        (set),
      .sw         (sw)
   );

   task automatic reset_model();
      for (int b = 0; b < 3; b++) begin
         lvl[b]  = 1'b0;
         up_p[b] = 1'b0;
         dn_p[b] = 1'b0;
         hist[b].delete();
         repeat (DB + 2) hist[b].push_back(1'b0);
      end
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      held    = 1'b0;
      exp_out = '0;
   endtask

   // One model step per rising edge: what the outputs must be after this edge
   task automatic model_step();
      bit [2:0] r;
      bit       all_diff;
      cyc++;
      r = {b_sw, b_set, b_inc};
      if (!rst_n) begin
         reset_model();
         model_valid = 1'b1;
         return;
      end
      exp_out = '0;
      for (int i = 0; i < 4; i++) begin
         if (pend[i]) begin
            exp_out[i] = 1'b1;
            pend[i]    = 1'b0;
            break;
         end
      end
      if (up_p[1]) pend[0] = 1'b1;
      if (up_p[2]) pend[1] = 1'b1;
      if (up_p[0]) begin
         held       = 1'b1;
         press_edge = cyc - 1;
      end
      if (dn_p[0] && held) begin
         pend[3] = 1'b1;
         held    = 1'b0;
      end
      if (held && cyc == press_edge + int'(LONG)) begin
         pend[2] = 1'b1;
         held    = 1'b0;
      end
      // a level flips once the last DB synchronised samples all disagree with it
      for (int b = 0; b < 3; b++) begin
         hist[b].push_front(r[b]);
         void'(hist[b].pop_back());
         all_diff = 1'b1;
         for (int k = 2; k <= int'(DB) + 1; k++) begin
            if (hist[b][k] == lvl[b]) all_diff = 1'b0;
         end
         up_p[b] = 1'b0;
         dn_p[b] = 1'b0;
         if (all_diff) begin
            lvl[b]  = !lvl[b];
            up_p[b] = lvl[b];
            dn_p[b] = !lvl[b];
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Compare process: every cycle, plus pulse bookkeeping for directed checks
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            checks++;
            if ({inc_short, inc_long, sw, set} !== exp_out) begin
               errors++;
               $display("FAIL outputs cyc=%0d: got short/long/sw/set=%b expected %b",
                        cyc, {inc_short, inc_long, sw, set}, exp_out);
            end
            checks++;
            if ((32'(inc_short) + 32'(inc_long) + 32'(sw) + 32'(set)) > 1) begin
               errors++;
               $display("FAIL onehot cyc=%0d: got %b expected at most one high",
                        cyc, {inc_short, inc_long, sw, set});
            end
            if (set === 1'b1) begin n_set++; if (first_set < 0) first_set = cyc; end
            if (sw === 1'b1) begin n_sw++; if (first_sw < 0) first_sw = cyc; end
            if (inc_long === 1'b1) begin n_long++; if (first_long < 0) first_long = cyc; end
            if (inc_short === 1'b1) begin n_short++; if (first_short < 0) first_short = cyc; end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic clr_counts();
      n_set = 0; n_sw = 0; n_long = 0; n_short = 0;
      first_set = -1; first_sw = -1; first_long = -1; first_short = -1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int press, rel, post;
      int cnt [3];
      clr_counts();
      wait_cyc(4);
      rst_n = 1'b1;
      check("reset_outputs", int'({inc_short, inc_long, sw, set}), 0);
      wait_cyc(30);

      // set press: one pulse 19 cycles after press edge, nothing on release
      clr_counts();
      b_set = 1'b1; press = cyc + 1;
      wait_cyc(50);
      b_set = 1'b0;
      wait_cyc(40);
      check("set_count", n_set, 1);
      check("set_latency", first_set - press, 19);
      check("set_others", n_sw + n_long + n_short, 0);

      // short inc press
      clr_counts();
      b_inc = 1'b1;
      wait_cyc(200);
      b_inc = 1'b0; rel = cyc + 1;
      wait_cyc(40);
      check("short_count", n_short, 1);
      check("short_latency", first_short - rel, 19);
      check("short_no_long", n_long, 0);

      // long inc hold
      clr_counts();
      b_inc = 1'b1; press = cyc + 1;
      wait_cyc(3000);
      b_inc = 1'b0;
      wait_cyc(40);
      check("long_count", n_long, 1);
      check("long_latency", first_long - press, 1018);
      check("long_no_short", n_short, 0);

      // sw glitches then a clean press
      clr_counts();
      repeat (6) begin
         b_sw = 1'b1; wait_cyc(10);
         b_sw = 1'b0; wait_cyc(5);
      end
      wait_cyc(30);
      check("glitch_no_sw", n_sw, 0);
      b_sw = 1'b1; wait_cyc(40);
      b_sw = 1'b0; wait_cyc(40);
      check("sw_after_glitch", n_sw, 1);

      // simultaneous set and sw
      clr_counts();
      b_set = 1'b1; b_sw = 1'b1; press = cyc + 1;
      wait_cyc(50);
      b_set = 1'b0; b_sw = 1'b0;
      wait_cyc(40);
      check("simul_set_latency", first_set - press, 19);
      check("simul_sw_latency", first_sw - press, 20);

      // reset while inc held
      clr_counts();
      b_inc = 1'b1;
      wait_cyc(500);
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1; post = cyc + 1;
      wait_cyc(1200);
      b_inc = 1'b0;
      wait_cyc(40);
      check("rst_no_short", n_short, 0);
      check("rst_long_count", n_long, 1);
      check("rst_long_latency", first_long - post, 1018);

      // randomized activity, model compared every cycle
      for (int b = 0; b < 3; b++) cnt[b] = 1;
      for (int i = 0; i < 30000; i++) begin
         for (int b = 0; b < 3; b++) begin
            cnt[b]--;
            if (cnt[b] == 0) begin
               case (b)
                  0: b_inc = ~b_inc;
                  1: b_set = ~b_set;
                  default: b_sw = ~b_sw;
               endcase
               cnt[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                                    : int'($urandom_range(15, 1300));
            end
         end
         if ($urandom_range(0, 4999) == 0) rst_n = 1'b0;
         else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
         wait_cyc(1);
      end
      rst_n = 1'b1;
      b_inc = 1'b0; b_set = 1'b0; b_sw = 1'b0;
      wait_cyc(1100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Front end that produces the single-cycle button events `inc_short`, `inc_long`, `set` and `sw` consumed by the clock/alarm/stopwatch control FSM.
- Synchronises, debounces and classifies three raw push-buttons.
- Guarantees at most one event output is high in any cycle, because the FSM only acts when exactly one event is asserted.
- Sits between the board button pins and the FSM, in the `clk` domain.

Parameters:
- DB_CYCLES, 16, consecutive `clk` cycles a synchronised input must differ from its debounced level before that level flips (legal range ≥2).
- LONG_CYCLES, 1000, debounced hold duration in cycles at which an inc press becomes `inc_long` (must be > DB_CYCLES).
- CNT_W, 20, width of the debounce and hold counters; must hold LONG_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- btn_inc_raw  input  1  raw inc button, active-high, asynchronous to clk
- btn_set_raw  input  1  raw set button, active-high, asynchronous
- btn_sw_raw  input  1  raw stopwatch button, active-high, asynchronous
- inc_short  output  1  one-cycle pulse: inc pressed and released before long threshold
- inc_long  output  1  one-cycle pulse: inc held LONG_CYCLES
- set  output  1  one-cycle pulse: set pressed
- sw  output  1  one-cycle pulse: sw pressed

Behaviour:
- Reset (`rst_n` = 0 at a clk edge): all outputs 0; synchronisers, debounced levels, counters, pending flags and the long-fired flag cleared; debounced levels read "released".
- Synchronisation: each raw input passes through 2 flops.
- Debounce, per button:
  - The counter increments each cycle the synchronised value differs from the debounced level.
  - It clears to 0 on any cycle they match.
  - On the DB_CYCLES-th consecutive differing cycle the debounced level flips and the counter clears.
  - Glitches shorter than DB_CYCLES cycles produce no level change.
- set / sw: a debounced 0→1 edge raises that button's pending flag. Release generates nothing.
- inc classifier, FSM states IDLE, HELD, LONG_DONE:
  - IDLE: on a debounced inc press, clear the hold counter and go to HELD.
  - HELD: the hold counter increments each cycle while pressed.
    - When the counter reaches LONG_CYCLES-1 while still pressed, raise pending_long and go to LONG_DONE.
    - On a debounced release before that, raise pending_short and go to IDLE.
  - LONG_DONE: on debounced release, go to IDLE with no event. Exactly one inc event is produced per press.
- Output arbiter (registered):
  - Each cycle, emit at most one pulse from the pending flags, priority set > sw > inc_long > inc_short.
  - Clear the emitted flag in the same cycle.
  - Lower-priority pending events are emitted in later cycles, one per cycle.
- Merging: a new event arriving while the same event's flag is still pending is merged; only one pulse is emitted.
- Latency, uncontested: the output pulse is high in cycle DB_CYCLES+3 after the first clk edge that samples the raw level change.
  - This applies to set/sw on press and to inc_short on release.
  - inc_long is high DB_CYCLES+3+LONG_CYCLES-1 cycles after the press edge.
- Pulse width: every output pulse is exactly 1 cycle.
- Reset mid-operation:
  - Pending events are discarded.
  - A button still held after reset release is seen as a fresh press after debounce.
  - For inc, the hold time restarts from the post-reset debounced edge.
- Wrap-around: the hold counter saturates and never wraps; LONG_CYCLES ≤ 2^CNT_W - 1.

Test Plan (defaults unless noted):
- Press btn_set_raw for 50 cycles, clean, then release -> set high for exactly 1 cycle, 19 cycles after the press edge; nothing on release; other outputs stay 0.
- Press btn_inc_raw for 200 cycles, then release -> no output during hold; inc_short single pulse 19 cycles after release; inc_long never asserted.
- Hold btn_inc_raw for 3000 cycles -> inc_long single pulse 1018 cycles after the press edge; no pulse at release; inc_short never asserted.
- Toggle btn_sw_raw with 10-cycle high glitches separated by 5-cycle lows, 6 times -> no output. Then hold high 40 cycles -> one sw pulse.
- Raise btn_set_raw and btn_sw_raw on the same cycle -> set pulse in cycle 19, sw pulse in cycle 20; never both high together.
- Hold btn_inc_raw for 500 cycles, assert rst_n = 0 for 3 cycles while still held, keep held for 1200 more cycles -> no output during reset; no inc_short; inc_long pulse 1018 cycles after the post-reset edge.
